// File: rtl/multiexp_fp2_feeder.sv
// -----------------------------------------------------------------------------
// multiexp_fp2_feeder
//
// Buffers up to MAX_IN scalar/point records written over a streaming load
// port, then replays them KEY_BITS times (one pass per scalar bit, MSB first)
// towards the multiexp core. Each record is emitted as one scalar word followed
// by NUM_WRDS point words. On the scalar word the scalar is pre-shifted left by
// the pass number (mod 2^KEY_BITS) so the bit under test sits at KEY_BITS-1.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_load_*                record load stream (dat/val/sop/eop in, rdy out);
//                           word position is taken from the write address only
//   i_start, i_clr          start a replay / discard records (IDLE only)
//   o_pnt_scl_*             replay stream to the core (dat/val/sop/eop/ctl out,
//                           rdy in)
//   o_num_in                number of stored records, zero-extended
//   o_busy                  high while streaming
//   o_done                  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module multiexp_fp2_feeder #(
   parameter int DAT_BITS = 381,
   parameter int NUM_WRDS = 6,
   parameter int KEY_BITS = 256,
   parameter int MAX_IN   = 16,
   parameter int CTL_BITS = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DAT_BITS-1:0] i_load_dat,
   input  logic                i_load_val,
   input  logic                i_load_sop,
   input  logic                i_load_eop,
   output logic                i_load_rdy,
   input  logic                i_start,
   input  logic                i_clr,
   output logic [DAT_BITS-1:0] o_pnt_scl_dat,
   output logic                o_pnt_scl_val,
   output logic                o_pnt_scl_sop,
   output logic                o_pnt_scl_eop,
   output logic [CTL_BITS-1:0] o_pnt_scl_ctl,
   input  logic                o_pnt_scl_rdy,
   output logic [63:0]         o_num_in,
   output logic                o_busy,
   output logic                o_done
);

   localparam int REC_WRDS = NUM_WRDS + 1;
   localparam int DEPTH    = MAX_IN * REC_WRDS;
   localparam int AW       = $clog2(DEPTH + 1);
   localparam int RAM_AW   = $clog2(DEPTH);
   localparam int REC_W    = $clog2(MAX_IN + 1);
   localparam int WRD_W    = $clog2(REC_WRDS);
   localparam int PASS_W   = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

   localparam logic [REC_W-1:0]  MAX_REC   = REC_W'(MAX_IN);
   localparam logic [WRD_W-1:0]  LAST_WRD  = WRD_W'(NUM_WRDS);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(KEY_BITS - 1);
   localparam logic [AW-1:0]     REC_STEP  = AW'(REC_WRDS);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]          state_reg;
   logic [REC_W-1:0]    num_rec_reg;
   logic [AW-1:0]       ld_base_reg;      // num_rec * REC_WRDS, kept incrementally
   logic [WRD_W-1:0]    ld_wrd_reg;       // word position inside the record being loaded

   // Read-side (issue) counters run ahead of the output by up to three words.
   logic [PASS_W-1:0]   pass_reg;
   logic [REC_W-1:0]    rec_reg;
   logic [WRD_W-1:0]    wrd_reg;
   logic [AW-1:0]       rd_base_reg;
   logic                issue_done_reg;

   // Tags travelling alongside the one-cycle RAM read.
   logic                rd_pend_reg, rd_sop_reg, rd_eop_reg, rd_last_reg;
   logic [PASS_W-1:0]   rd_pass_reg;

   logic [DAT_BITS-1:0] ram [DEPTH];
   logic [DAT_BITS-1:0] ram_q_reg;

   logic [DAT_BITS-1:0] fifo_dat_reg [2];
   logic [1:0]          fifo_sop_reg, fifo_eop_reg, fifo_last_reg;
   logic                fifo_rd_ptr_reg, fifo_wr_ptr_reg;
   logic [1:0]          fifo_cnt_reg;

   logic [DAT_BITS-1:0] out_dat_reg;
   logic                out_val_reg, out_sop_reg, out_eop_reg, out_last_reg;

   logic                is_idle, is_stream, load_fire, start_go, wr_en;
   logic [AW-1:0]       wr_addr, rd_addr;
   logic                out_pop, out_free, fifo_pop, fifo_push, issue, issue_last;
   logic [2:0]          occ;
   logic [REC_W-1:0]    rec_last;
   logic [KEY_BITS-1:0] key_shift;
   logic [DAT_BITS-1:0] ret_dat;
   logic                unused_load_flags;

   // Framing flags on the load side are informational; position comes from wr_addr.
   assign unused_load_flags = i_load_sop ^ i_load_eop;

   assign is_idle    = (state_reg == ST_IDLE);
   assign is_stream  = (state_reg == ST_STREAM);
   assign i_load_rdy = is_idle && (num_rec_reg < MAX_REC);
   assign load_fire  = i_load_val && i_load_rdy;
   assign start_go   = is_idle && i_start && !i_clr && (num_rec_reg != '0);
   assign wr_en      = load_fire && !i_clr && !start_go;
   assign wr_addr    = ld_base_reg + AW'(ld_wrd_reg);
   assign rd_addr    = rd_base_reg + AW'(wrd_reg);
   assign rec_last   = num_rec_reg - REC_W'(1);

   assign out_pop    = out_val_reg && o_pnt_scl_rdy;
   assign out_free   = !out_val_reg || o_pnt_scl_rdy;
   assign fifo_pop   = out_free && (fifo_cnt_reg != 2'd0);
   // Returning RAM data bypasses the skid buffer when the output can take it.
   assign fifo_push  = rd_pend_reg && !(out_free && (fifo_cnt_reg == 2'd0));

   // Words held after this cycle's pop: output reg + skid entries + read in flight.
   // Keeping this below three guarantees the skid buffer never overflows.
   assign occ = {2'b00, out_val_reg} + {1'b0, fifo_cnt_reg} + {2'b00, rd_pend_reg}
              - {2'b00, out_pop};
   // The first read is issued in the start cycle itself; counters are zero in IDLE.
   assign issue = start_go || (is_stream && !issue_done_reg && (occ < 3'd3));
   assign issue_last = (pass_reg == LAST_PASS) && (rec_reg == rec_last)
                    && (wrd_reg == LAST_WRD);

   assign key_shift = ram_q_reg[KEY_BITS-1:0] << rd_pass_reg;

   always_comb begin
      ret_dat = ram_q_reg;
      if (rd_sop_reg) begin
         ret_dat                 = '0;
         ret_dat[KEY_BITS-1:0]   = key_shift;
      end
   end

   // Record storage and skid-buffer payload: no reset needed, contents are
   // always qualified by counters that are reset.
   always_ff @(posedge i_clk) begin
      if (wr_en)
         ram[wr_addr[RAM_AW-1:0]] <= i_load_dat;
      if (issue)
         ram_q_reg <= ram[rd_addr[RAM_AW-1:0]];
      if (fifo_push) begin
         fifo_dat_reg[fifo_wr_ptr_reg]  <= ret_dat;
         fifo_sop_reg[fifo_wr_ptr_reg]  <= rd_sop_reg;
         fifo_eop_reg[fifo_wr_ptr_reg]  <= rd_eop_reg;
         fifo_last_reg[fifo_wr_ptr_reg] <= rd_last_reg;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg       <= ST_IDLE;
         num_rec_reg     <= '0;
         ld_base_reg     <= '0;
         ld_wrd_reg      <= '0;
         pass_reg        <= '0;
         rec_reg         <= '0;
         wrd_reg         <= '0;
         rd_base_reg     <= '0;
         issue_done_reg  <= 1'b0;
         rd_pend_reg     <= 1'b0;
         rd_sop_reg      <= 1'b0;
         rd_eop_reg      <= 1'b0;
         rd_last_reg     <= 1'b0;
         rd_pass_reg     <= '0;
         fifo_rd_ptr_reg <= 1'b0;
         fifo_wr_ptr_reg <= 1'b0;
         fifo_cnt_reg    <= 2'd0;
         out_dat_reg     <= '0;
         out_val_reg     <= 1'b0;
         out_sop_reg     <= 1'b0;
         out_eop_reg     <= 1'b0;
         out_last_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_clr) begin
                  num_rec_reg <= '0;
                  ld_base_reg <= '0;
                  ld_wrd_reg  <= '0;
               end else if (start_go) begin
                  state_reg  <= ST_STREAM;
                  ld_wrd_reg <= '0;      // drop any partially loaded record
               end else if (load_fire) begin
                  if (ld_wrd_reg == LAST_WRD) begin
                     ld_wrd_reg  <= '0;
                     ld_base_reg <= ld_base_reg + REC_STEP;
                     num_rec_reg <= num_rec_reg + REC_W'(1);
                  end else begin
                     ld_wrd_reg <= ld_wrd_reg + WRD_W'(1);
                  end
               end
            end
            ST_STREAM: begin
               if (out_pop && out_last_reg)
                  state_reg <= ST_DONE;
            end
            ST_DONE: begin
               state_reg      <= ST_IDLE;
               pass_reg       <= '0;
               issue_done_reg <= 1'b0;
            end
            default: state_reg <= ST_IDLE;
         endcase

         if (issue) begin
            if (wrd_reg == LAST_WRD) begin
               wrd_reg <= '0;
               if (rec_reg == rec_last) begin
                  rec_reg     <= '0;
                  rd_base_reg <= '0;
                  if (pass_reg == LAST_PASS)
                     issue_done_reg <= 1'b1;
                  else
                     pass_reg <= pass_reg + PASS_W'(1);
               end else begin
                  rec_reg     <= rec_reg + REC_W'(1);
                  rd_base_reg <= rd_base_reg + REC_STEP;
               end
            end else begin
               wrd_reg <= wrd_reg + WRD_W'(1);
            end
            rd_sop_reg  <= (wrd_reg == '0);
            rd_eop_reg  <= (wrd_reg == LAST_WRD);
            rd_last_reg <= issue_last;
            rd_pass_reg <= pass_reg;
         end
         rd_pend_reg <= issue;

         if (fifo_push)
            fifo_wr_ptr_reg <= !fifo_wr_ptr_reg;
         if (fifo_pop)
            fifo_rd_ptr_reg <= !fifo_rd_ptr_reg;
         fifo_cnt_reg <= fifo_cnt_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};

         // Output register reloads only when empty or being accepted, so the
         // presented word holds steady under backpressure.
         if (out_free) begin
            out_val_reg <= (fifo_cnt_reg != 2'd0) || rd_pend_reg;
            if (fifo_cnt_reg != 2'd0) begin
               out_dat_reg  <= fifo_dat_reg[fifo_rd_ptr_reg];
               out_sop_reg  <= fifo_sop_reg[fifo_rd_ptr_reg];
               out_eop_reg  <= fifo_eop_reg[fifo_rd_ptr_reg];
               out_last_reg <= fifo_last_reg[fifo_rd_ptr_reg];
            end else if (rd_pend_reg) begin
               out_dat_reg  <= ret_dat;
               out_sop_reg  <= rd_sop_reg;
               out_eop_reg  <= rd_eop_reg;
               out_last_reg <= rd_last_reg;
            end
         end
      end
   end

   assign o_pnt_scl_dat = out_dat_reg;
   assign o_pnt_scl_val = out_val_reg;
   assign o_pnt_scl_sop = out_sop_reg;
   assign o_pnt_scl_eop = out_eop_reg;
   assign o_pnt_scl_ctl = '0;
   assign o_num_in      = 64'(num_rec_reg);
   assign o_busy        = is_stream;
   assign o_done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
// -----------------------------------------------------------------------------
// tb_multiexp_fp2_feeder
//
// Self-checking bench for multiexp_fp2_feeder built with KEY_BITS=4 and a
// 32-bit word. A reference model keeps the stored words by address and derives
// the expected replay stream directly from the load/replay rules.
// -----------------------------------------------------------------------------
module tb_multiexp_fp2_feeder;

   localparam int DAT_BITS = 32;
   localparam int NUM_WRDS = 6;
   localparam int KEY_BITS = 4;
   localparam int MAX_IN   = 16;
   localparam int CTL_BITS = 16;
   localparam int REC_WRDS = NUM_WRDS + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic [DAT_BITS-1:0] load_dat;
   logic                load_val, load_sop, load_eop, load_rdy;
   logic                start, clr;
   logic [DAT_BITS-1:0] pnt_dat;
   logic                pnt_val, pnt_sop, pnt_eop, pnt_rdy;
   logic [CTL_BITS-1:0] pnt_ctl;
   logic [63:0]         num_in;
   logic                busy, done;

   multiexp_fp2_feeder #(
      .DAT_BITS(DAT_BITS), .NUM_WRDS(NUM_WRDS), .KEY_BITS(KEY_BITS),
      .MAX_IN(MAX_IN), .CTL_BITS(CTL_BITS)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_load_dat(load_dat), .i_load_val(load_val), .i_load_sop(load_sop),
      .i_load_eop(load_eop), .i_load_rdy(load_rdy),
      .i_start(start), .i_clr(clr),
      .o_pnt_scl_dat(pnt_dat), .o_pnt_scl_val(pnt_val), .o_pnt_scl_sop(pnt_sop),
      .o_pnt_scl_eop(pnt_eop), .o_pnt_scl_ctl(pnt_ctl), .o_pnt_scl_rdy(pnt_rdy),
      .o_num_in(num_in), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DAT_BITS-1:0] dat;
      bit                  sop;
      bit                  eop;
   } word_t;

   logic [DAT_BITS-1:0] m_mem [MAX_IN*REC_WRDS];
   int                  m_wr  = 0;
   int                  m_num = 0;
   word_t               exp_q[$];

   function automatic void build_exp();
      logic [DAT_BITS-1:0] s;
      logic [DAT_BITS-1:0] mask;
      mask = (DAT_BITS'(1) << KEY_BITS) - DAT_BITS'(1);
      exp_q.delete();
      for (int p = 0; p < KEY_BITS; p++)
         for (int r = 0; r < m_num; r++)
            for (int w = 0; w < REC_WRDS; w++) begin
               if (w == 0) s = (m_mem[r*REC_WRDS] << p) & mask;
               else        s = m_mem[r*REC_WRDS + w];
               exp_q.push_back('{s, (w == 0), (w == NUM_WRDS)});
            end
   endfunction

   task automatic load_word(input logic [DAT_BITS-1:0] d);
      bit exp_rdy;
      exp_rdy  = (m_num < MAX_IN);
      load_dat = d;
      load_val = 1'b1;
      load_sop = ((m_wr % REC_WRDS) == 0);
      load_eop = ((m_wr % REC_WRDS) == NUM_WRDS);
      check("load_rdy", load_rdy, exp_rdy);
      if (exp_rdy) begin
         m_mem[m_wr] = d;
         m_wr++;
         if ((m_wr % REC_WRDS) == 0) m_num++;
      end
      step();
      load_val = 1'b0;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) load_word($urandom());
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      m_num = 0;
      m_wr  = 0;
   endtask

   task automatic do_start(input bit with_clr);
      start = 1'b1;
      clr   = with_clr;
      step();
      start = 1'b0;
      clr   = 1'b0;
      if (with_clr) begin
         m_num = 0;
         m_wr  = 0;
         exp_q.delete();
      end else if (m_num != 0) begin
         m_wr = m_num * REC_WRDS;
         build_exp();
      end
   endtask

   // Drive random backpressure and compare every accepted word with exp_q.
   // stop_at>0 returns right after that many handshakes (no done check).
   task automatic collect(input int pct, input int stop_at, output int got);
      int  idx, cyc, first, limit;
      bit  prev_val, prev_rdy, fire;
      logic [DAT_BITS+1:0] prev_w;
      idx = 0; cyc = 0; first = -1; prev_val = 0; prev_rdy = 0; prev_w = '0;
      limit = exp_q.size() * 8 + 50;
      got = 0;
      while (cyc < limit) begin
         pnt_rdy = ($urandom_range(0, 99) < pct);
         if (prev_val && !prev_rdy) begin
            check("hold_val", pnt_val, 1);
            check("hold_word", {pnt_dat, pnt_sop, pnt_eop}, prev_w);
         end
         check("done_low", done, 0);
         check("num_in_stream", num_in, m_num);
         if (pnt_val && first < 0) begin
            first = cyc;
            check("first_val_cycle", first, 1);
            check("busy_stream", busy, 1);
         end
         fire = pnt_val && pnt_rdy;
         if (fire) begin
            if (idx < exp_q.size()) begin
               check("dat", pnt_dat, exp_q[idx].dat);
               check("sop", pnt_sop, exp_q[idx].sop);
               check("eop", pnt_eop, exp_q[idx].eop);
               check("ctl", pnt_ctl, 0);
            end else begin
               check("word_count", idx + 1, exp_q.size());
            end
         end
         prev_val = pnt_val;
         prev_rdy = pnt_rdy;
         prev_w   = {pnt_dat, pnt_sop, pnt_eop};
         step();
         cyc++;
         if (fire) begin
            idx++;
            if (stop_at > 0 && idx == stop_at) begin
               got = idx;
               pnt_rdy = 1'b0;
               return;
            end
            if (idx == exp_q.size()) begin
               check("done_pulse", done, 1);
               check("busy_at_done", busy, 0);
               pnt_rdy = 1'b0;
               step();
               check("done_clear", done, 0);
               check("busy_idle", busy, 0);
               got = idx;
               return;
            end
         end
      end
      check("stream_timeout", idx, exp_q.size());
      got = idx;
      pnt_rdy = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit pre_clr;
      int n_words;
      bit clr_start;
      int rdy_pct;
      int exp_num;
      int exp_words;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int got;
      logic [DAT_BITS-1:0] scal_tab [4];

      vecs[0] = '{1'b1, 21,  1'b0, 50,  3,  84};   // three records, ~50% rdy
      vecs[1] = '{1'b0, 0,   1'b0, 100, 3,  84};   // replay of retained records
      vecs[2] = '{1'b1, 10,  1'b0, 100, 1,  28};   // 1 record + 3 stray words
      vecs[3] = '{1'b0, 7,   1'b0, 60,  2,  56};   // next record lands at addr 7
      vecs[4] = '{1'b1, 0,   1'b0, 100, 0,  0};    // start with nothing stored
      vecs[5] = '{1'b1, 14,  1'b1, 100, 2,  0};    // clr together with start
      vecs[6] = '{1'b1, 113, 1'b0, 70,  16, 448};  // fill plus one extra word

      scal_tab[0] = 32'hA;
      scal_tab[1] = 32'h4;
      scal_tab[2] = 32'h8;
      scal_tab[3] = 32'h0;

      rst = 1'b1; load_dat = '0; load_val = 0; load_sop = 0; load_eop = 0;
      start = 0; clr = 0; pnt_rdy = 0;
      step(); step(); step();
      check("rst_val", pnt_val, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_num_in", num_in, 0);
      check("rst_load_rdy", load_rdy, 1);
      rst = 1'b0;
      step();
      $display("reset: val=%0b busy=%0b num_in=%0d", pnt_val, busy, num_in);

      // Single record, scalar 1010, checked against hand-written scalar words.
      load_word(32'hA);
      load_words(NUM_WRDS);
      check("spec1_num_in", num_in, 1);
      do_start(1'b0);
      for (int i = 0; i < exp_q.size(); i++)
         if ((i % REC_WRDS) == 0) exp_q[i].dat = scal_tab[i / REC_WRDS];
      collect(100, 0, got);
      check("spec1_words", got, 28);
      $display("spec1: one record scalar=1010 streamed %0d words", got);

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].pre_clr) pulse_clr();
         load_words(vecs[v].n_words);
         check("num_in_load", num_in, vecs[v].exp_num);
         do_start(vecs[v].clr_start);
         got = 0;
         if (vecs[v].exp_words > 0) begin
            collect(vecs[v].rdy_pct, 0, got);
            check("words", got, vecs[v].exp_words);
         end else begin
            for (int c = 0; c < 4; c++) begin
               check("idle_val", pnt_val, 0);
               check("idle_busy", busy, 0);
               step();
            end
         end
         check("num_in_after", num_in, m_num);
         $display("vec %0d: loaded %0d words clr_start=%0b num_in=%0d streamed %0d words",
                  v, vecs[v].n_words, vecs[v].clr_start, num_in, got);
      end

      // Reset in the middle of pass 2, record 1.
      pulse_clr();
      load_words(3 * REC_WRDS);
      do_start(1'b0);
      collect(100, 2 * 3 * REC_WRDS + REC_WRDS, got);
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_num = 0;
      m_wr  = 0;
      check("midrst_val", pnt_val, 0);
      check("midrst_busy", busy, 0);
      check("midrst_num_in", num_in, 0);
      $display("midstream reset after %0d words: val=%0b busy=%0b num_in=%0d",
               got, pnt_val, busy, num_in);
      step();
      load_words(REC_WRDS);
      do_start(1'b0);
      collect(100, 0, got);
      check("midrst_replay_words", got, 28);
      $display("post-reset replay: streamed %0d words", got);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/multiexp_fp2_feeder.md
# multiexp_fp2_feeder

Source side of the multiexp core scalar/point stream. Buffers up to MAX_IN scalar/point records loaded over AXI stream, then replays them KEY_BITS times, one pass per scalar bit MSB-first, in the core's word format (scalar word, then NUM_WRDS point words). Each pass presents the scalar pre-shifted so the bit under test is at KEY_BITS-1. It sits between host/DMA load logic and the multiexp core input, and drives the core's point-count input.

## Interface
- DAT_BITS, 381: width of one FE word.
- NUM_WRDS, 6: point words per record (Fp2 x,y,z).
- KEY_BITS, 256: scalar width; must be ≤ DAT_BITS.
- MAX_IN, 16: maximum stored records.
- CTL_BITS, 16: ctl field width.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_load_if, if_axi_stream.sink, DAT_BITS: record load; sop on the scalar word, eop on point word NUM_WRDS-1.
- i_start, in, 1: start a replay; sampled only in IDLE.
- i_clr, in, 1: discard stored records; sampled only in IDLE.
- o_pnt_scl_if, if_axi_stream.source, DAT_BITS: replay stream to the core.
- o_num_in, out, 64: count of stored records, zero-extended.
- o_busy, out, 1: high in STREAM.
- o_done, out, 1: one-cycle pulse after the last word of the final pass is accepted.

## Operation
- Storage: a single RAM, MAX_IN*(NUM_WRDS+1) words deep, DAT_BITS wide, with 1-cycle read latency.
- Record r word w lives at address r*(NUM_WRDS+1)+w.
- States: IDLE, STREAM, DONE.
- **IDLE, loading:**
  - i_load_if.rdy = 1 when num_rec < MAX_IN.
  - Each accepted word is written at wr_addr, then wr_addr increments.
  - On an accepted eop, num_rec increments.
  - sop/eop are not checked. Word position is derived only from wr_addr.
  - At num_rec == MAX_IN, rdy = 0.
- **i_clr (IDLE):** clears num_rec and wr_addr the next cycle. If asserted together with i_start, i_clr wins and the start is ignored.
- **i_start (IDLE):**
  - If num_rec == 0, i_start is ignored.
  - Otherwise go to STREAM with pass=0, rec=0, wrd=0.
  - A partial record (wr_addr not on a record boundary) is discarded: wr_addr is truncated back to num_rec*(NUM_WRDS+1).
- **STREAM:**
  - Emits rec 0..num_rec-1 for pass 0..KEY_BITS-1.
  - wrd 0: dat = zero-extend((scalar << pass) mod 2^KEY_BITS), sop=1.
  - wrd 1..NUM_WRDS: stored point words; eop on wrd NUM_WRDS.
  - ctl = 0 on every word (ctl[0]=0 is normal mode).
  - Counters advance on each output handshake. wrd wraps after NUM_WRDS, then rec wraps after num_rec-1, then pass increments.
  - After the handshake of the last word of pass KEY_BITS-1, go to DONE.
  - i_load_if.rdy = 0 in STREAM.
- **DONE:** for one cycle, o_done=1, then go to IDLE. Stored records are retained, so i_start replays them.
- o_num_in = num_rec at all times. It is stable throughout STREAM.
- **Reset (any state, including mid-stream):** state=IDLE, num_rec=0, wr_addr=0, o_pnt_scl_if.val=0, o_done=0, o_busy=0, counters=0. RAM contents are not cleared.

## Timing
- All outputs are registered.
- o_pnt_scl_if.val rises 2 cycles after the i_start cycle (RAM read plus output register).
- o_pnt_scl_if follows AXI-stream rules:
  - Once val=1, dat/sop/eop/ctl hold until rdy.
  - val is never dropped without a handshake.
- A 2-entry skid/prefetch buffer absorbs the RAM latency. With rdy held high, one word is transferred per cycle, with no bubbles across record, pass, or wrap boundaries.
- Total words per replay = KEY_BITS*num_rec*(NUM_WRDS+1). o_done is asserted the cycle after the final handshake.
- The load path accepts 1 word/cycle. A write is visible to a read issued 1 or more cycles later.
- i_load_if.rdy is combinational from state and num_rec.

## Test plan
- **Load and replay, 1 record:** KEY_BITS=4 build, scalar=4'b1010, point words P0..P5, i_start, rdy=1.
  - 28 words out: scalar words 1010, 0100, 1000, 0000; point words repeated in order.
  - sop on each scalar word, eop on each P5.
  - o_done one cycle after the last word.
- **Three records, random output backpressure (rdy ~50%):** every word matches the model, val never drops unacknowledged, o_num_in=3.
- **Fill to MAX_IN:** load MAX_IN records plus 1 extra word.
  - i_load_if.rdy=0 after the MAX_IN-th eop; the extra word is not accepted.
  - Replay count is correct.
- **Start with 0 records:** i_start is ignored, o_busy stays 0. i_clr together with i_start after a load → no stream, num_rec=0.
- **Reset mid-STREAM (pass 2, rec 1):**
  - Next cycle: val=0, o_busy=0, o_num_in=0.
  - A fresh load of 1 record, then i_start, gives a correct 28-word replay.
- **Partial record then start:** load 1 full record plus 3 words, i_start → replay covers 1 record only. Next load lands at record 1, address 7.
